vp_sync_decoder: RTL and testbench
==================================

# vp_sync_decoder

Synthesizable receive-side decoder for the video-processing pixel stream: consumes the DE/HSYNC/VSYNC/RGB stream produced by the HDMI input source and re-emits it registered, annotated with pixel coordinates and frame markers. Checks frame geometry against the configured resolution and reports lock and errors. Sits directly after the HDMI input, ahead of any processing stage needing x/y position.

## Interface
- H_RES, 64, active pixels per line
- V_RES, 64, active lines per frame
- CW, 12, coordinate/counter width; must satisfy 2^CW > max(H_RES, V_RES)

Ports:
- hdmi_clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_de, in_hs, in_vs  in  1 each  input stream controls, active-high
- in_r, in_g, in_b  in  8 each  input pixel
- out_de, out_hs, out_vs  out  1 each  registered copies of inputs
- out_r, out_g, out_b  out  8 each  registered pixel
- out_x, out_y  out  CW each  coordinates of the current out_de pixel
- out_sof  out  1  first pixel of frame (x=0, y=0)
- out_eol  out  1  pixel with x=H_RES-1
- out_eof  out  1  pixel with x=H_RES-1, y=V_RES-1
- locked  out  1  last completed frame had correct geometry
- err_line  out  1  one-cycle pulse: line ended with wrong pixel count
- err_frame  out  1  one-cycle pulse: frame ended with wrong line count
- frame_cnt  out  16  good frames since reset, wraps

## Operation
- States: IDLE (after reset), RUN.
- IDLE: passthrough only; out_x/out_y held 0; out_sof/eol/eof held 0. in_vs rising edge → RUN, counters cleared.
- RUN: x counts in_de pixels from 0; on in_de falling edge, if x count ≠ H_RES → err_line; y increments on each in_de falling edge (any length). x clears on in_de falling edge.
- in_vs rising edge in RUN: frame evaluation. Good = (line count == V_RES) and no err_line in that frame. Good → locked=1, frame_cnt+1. Bad → locked=0; err_frame pulses if line count ≠ V_RES. Counters cleared; stay in RUN.
- Any err_line immediately clears locked.
- Overflow: x and y saturate at 2^CW−1; markers never asserted at out-of-range coordinates.
- Markers asserted only with out_de=1 and only in RUN.
- vs rising and in_de=1 in the same cycle: evaluation and counter clear happen first; the pixel is x=0, y=0 of the new frame (out_sof=1).
- in_hs is passed through only; it does not affect counting.

## Timing
- Latency: every output registered, exactly 1 cycle from the corresponding input.
- Edge detection uses registered previous in_vs/in_de; an edge at cycle n takes effect on outputs at n+1.
- err_line / err_frame: single-cycle pulses, same cycle as the out_de falling / out_vs rising.
- locked and frame_cnt update in the cycle out_vs rises.
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame discards the partial frame; a new in_vs rising edge is required before coordinates resume.

## Structure
- Shared package vp_pkg: state enum (IDLE, RUN), default CW.
- One sub-module vp_edge_det (registered rise/fall detect, 1-bit), instantiated for in_vs and in_de.

## Test plan
- Three clean 64×64 frames → locked=1 after first vs following frame 1, frame_cnt=2 at third vs; out_sof at first pixel, out_eol at x=63 each line, out_eof at (63,63); no errors.
- One line of 63 pixels in frame 2 → err_line pulse at that line end, locked=0 immediately, frame_cnt unchanged at next vs; frame 3 clean → locked=1.
- Frame of 63 lines → err_frame pulse at next vs rising, locked=0.
- Reset asserted mid-line at (20,10) → all outputs 0 next cycle; pixels before next vs show x=y=0 and no markers.
- Pixel data ramp → out_r/g/b equal in_r/g/b delayed exactly 1 cycle; out_x equals pixel index within line.
- vs rising coincident with in_de=1 → that pixel reported x=0, y=0, out_sof=1.

Source files
------------

// File: rtl/vp_pkg.sv
// Shared types and defaults for the video-pipeline sync decoder.
package vp_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vp_state_t;

    localparam int VP_CW    = 12;
    localparam int VP_H_RES = 64;
    localparam int VP_V_RES = 64;
endpackage

// File: rtl/vp_edge_det.sv
// Rise/fall detector: previous sample is registered, edges are flagged on the
// cycle the new level is present at the input.
module vp_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_d;
        end
    end

    assign o_rise = i_d & ~r_prev;
    assign o_fall = ~i_d & r_prev;
endmodule

// File: rtl/vp_sync_decoder.sv
// Receive-side sync decoder: registers the pixel stream, annotates x/y and
// frame markers, and checks line/frame geometry against H_RES x V_RES.
module vp_sync_decoder
    import vp_pkg::*;
#(
    parameter int H_RES = VP_H_RES,
    parameter int V_RES = VP_V_RES,
    parameter int CW    = VP_CW
) (
    input  logic          hdmi_clk,
    input  logic          rst_n,
    input  logic          in_de,
    input  logic          in_hs,
    input  logic          in_vs,
    input  logic [7:0]    in_r,
    input  logic [7:0]    in_g,
    input  logic [7:0]    in_b,
    output logic          out_de,
    output logic          out_hs,
    output logic          out_vs,
    output logic [7:0]    out_r,
    output logic [7:0]    out_g,
    output logic [7:0]    out_b,
    output logic [CW-1:0] out_x,
    output logic [CW-1:0] out_y,
    output logic          out_sof,
    output logic          out_eol,
    output logic          out_eof,
    output logic          locked,
    output logic          err_line,
    output logic          err_frame,
    output logic [15:0]   frame_cnt
);
    localparam logic [CW-1:0] H_LEN  = CW'(H_RES);
    localparam logic [CW-1:0] V_LEN  = CW'(V_RES);
    localparam logic [CW-1:0] H_LAST = CW'(H_RES - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_RES - 1);

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    vp_state_t     r_state;
    logic [CW-1:0] r_x_cnt;
    logic [CW-1:0] r_y_cnt;
    logic          r_frame_err;

    logic          w_vs_rise, w_vs_fall, w_de_rise, w_de_fall, w_unused;
    logic          w_run, w_pix, w_line_bad, w_frame_good;
    logic [CW-1:0] w_x, w_y, w_lines;

    vp_edge_det u_vs_edge (
        .i_clk   (hdmi_clk),
        .i_rst_n (rst_n),
        .i_d     (in_vs),
        .o_rise  (w_vs_rise),
        .o_fall  (w_vs_fall)
    );

    vp_edge_det u_de_edge (
        .i_clk   (hdmi_clk),
        .i_rst_n (rst_n),
        .i_d     (in_de),
        .o_rise  (w_de_rise),
        .o_fall  (w_de_fall)
    );

    assign w_unused = w_vs_fall ^ w_de_rise;

    // A vs rise clears the frame before the coincident pixel is labelled, so that
    // pixel becomes (0,0); a line ending in the same cycle still counts toward
    // the frame being evaluated.
    always_comb begin
        w_run        = (r_state == ST_RUN);
        w_pix        = in_de && (w_run || w_vs_rise);
        w_x          = w_vs_rise ? '0 : r_x_cnt;
        w_y          = w_vs_rise ? '0 : r_y_cnt;
        w_line_bad   = w_run && w_de_fall && (r_x_cnt != H_LEN);
        w_lines      = (w_run && w_de_fall) ? sat_inc(r_y_cnt) : r_y_cnt;
        w_frame_good = (w_lines == V_LEN) && !r_frame_err && !w_line_bad;
    end

    always_ff @(posedge hdmi_clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_frame_err <= 1'b0;
            out_de      <= 1'b0;
            out_hs      <= 1'b0;
            out_vs      <= 1'b0;
            out_r       <= '0;
            out_g       <= '0;
            out_b       <= '0;
            out_x       <= '0;
            out_y       <= '0;
            out_sof     <= 1'b0;
            out_eol     <= 1'b0;
            out_eof     <= 1'b0;
            locked      <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            out_de    <= in_de;
            out_hs    <= in_hs;
            out_vs    <= in_vs;
            out_r     <= in_r;
            out_g     <= in_g;
            out_b     <= in_b;
            err_line  <= w_line_bad;
            err_frame <= 1'b0;

            if (w_vs_rise) begin
                if (w_run) begin
                    locked    <= w_frame_good;
                    err_frame <= (w_lines != V_LEN);
                    if (w_frame_good) begin
                        frame_cnt <= frame_cnt + 16'd1;
                    end
                end
                r_state     <= ST_RUN;
                r_x_cnt     <= in_de ? CW'(1) : '0;
                r_y_cnt     <= '0;
                r_frame_err <= 1'b0;
            end else if (w_run) begin
                if (w_line_bad) begin
                    r_frame_err <= 1'b1;
                    locked      <= 1'b0;
                end
                if (w_de_fall) begin
                    r_x_cnt <= '0;
                    r_y_cnt <= sat_inc(r_y_cnt);
                end else if (in_de) begin
                    r_x_cnt <= sat_inc(r_x_cnt);
                end
            end

            if (w_pix) begin
                out_x   <= w_x;
                out_y   <= w_y;
                out_sof <= (w_x == '0) && (w_y == '0);
                out_eol <= (w_x == H_LAST);
                out_eof <= (w_x == H_LAST) && (w_y == V_LAST);
            end else begin
                out_x   <= '0;
                out_y   <= '0;
                out_sof <= 1'b0;
                out_eol <= 1'b0;
                out_eof <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vp_sync_decoder.sv
// Frame-structured random stimulus for vp_sync_decoder; expectations come from
// line/frame bookkeeping in the generator.
module tb_vp_sync_decoder;
    localparam int H    = 64;
    localparam int V    = 64;
    localparam int CW   = 12;
    localparam int XMAX = (1 << CW) - 1;

    logic          hdmi_clk = 1'b0;
    logic          rst_n    = 1'b0;
    logic          in_de    = 1'b0;
    logic          in_hs    = 1'b0;
    logic          in_vs    = 1'b0;
    logic [7:0]    in_r     = '0;
    logic [7:0]    in_g     = '0;
    logic [7:0]    in_b     = '0;
    logic          out_de, out_hs, out_vs;
    logic [7:0]    out_r, out_g, out_b;
    logic [CW-1:0] out_x, out_y;
    logic          out_sof, out_eol, out_eof;
    logic          locked, err_line, err_frame;
    logic [15:0]   frame_cnt;

    int total = 0;
    int bad   = 0;

    bit m_run    = 1'b0;
    bit m_locked = 1'b0;
    bit m_lerr   = 1'b0;
    int m_fcnt   = 0;
    int m_lines  = 0;

    always #5 hdmi_clk = ~hdmi_clk;

    vp_sync_decoder #(.H_RES(H), .V_RES(V), .CW(CW)) dut (
        .hdmi_clk  (hdmi_clk),
        .rst_n     (rst_n),
        .in_de     (in_de),
        .in_hs     (in_hs),
        .in_vs     (in_vs),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .out_de    (out_de),
        .out_hs    (out_hs),
        .out_vs    (out_vs),
        .out_r     (out_r),
        .out_g     (out_g),
        .out_b     (out_b),
        .out_x     (out_x),
        .out_y     (out_y),
        .out_sof   (out_sof),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .locked    (locked),
        .err_line  (err_line),
        .err_frame (err_frame),
        .frame_cnt (frame_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > XMAX) ? XMAX : v;
    endfunction

    // One clock: drive inputs, update the frame bookkeeping, check the outputs.
    // end_len >= 0 marks the first idle cycle after a line of that many pixels.
    task automatic step(input bit de, input bit vs, input bit rst_cyc, input int px,
                        input bit vs_rise, input int end_len);
        logic [26:0]     e_data;
        logic [2*CW-1:0] e_xy;
        logic [2:0]      e_mk;
        logic [18:0]     e_st;
        bit              e_el;
        bit              e_ef;
        int              ex;
        int              ey;
        in_de  = de;
        in_vs  = vs;
        in_hs  = 1'($urandom);
        in_r   = 8'(px);
        in_g   = 8'($urandom);
        in_b   = 8'($urandom);
        rst_n  = !rst_cyc;
        e_el   = 1'b0;
        e_ef   = 1'b0;
        e_data = {de, in_hs, vs, in_r, in_g, in_b};
        e_xy   = '0;
        e_mk   = '0;
        if (rst_cyc) begin
            m_run    = 1'b0;
            m_locked = 1'b0;
            m_lerr   = 1'b0;
            m_fcnt   = 0;
            m_lines  = 0;
            e_data   = '0;
            e_st     = '0;
        end else begin
            if (vs_rise) begin
                if (m_run) begin
                    e_ef = (m_lines != V);
                    if (m_lines == V && !m_lerr) begin
                        m_locked = 1'b1;
                        m_fcnt++;
                    end else begin
                        m_locked = 1'b0;
                    end
                end
                m_run   = 1'b1;
                m_lines = 0;
                m_lerr  = 1'b0;
            end
            if (end_len >= 0 && m_run) begin
                if (end_len != H) begin
                    e_el     = 1'b1;
                    m_lerr   = 1'b1;
                    m_locked = 1'b0;
                end
                m_lines++;
            end
            if (de && m_run) begin
                ex   = sat(px);
                ey   = sat(m_lines);
                e_xy = {CW'(ex), CW'(ey)};
                e_mk = {(ex == 0) && (ey == 0), ex == H - 1, (ex == H - 1) && (ey == V - 1)};
            end
            e_st = {m_locked, e_el, e_ef, 16'(m_fcnt)};
        end
        @(posedge hdmi_clk);
        #1;
        check_eq("data", {out_de, out_hs, out_vs, out_r, out_g, out_b}, e_data);
        check_eq("xy", {out_x, out_y}, e_xy);
        check_eq("mark", {out_sof, out_eol, out_eof}, e_mk);
        check_eq("status", {locked, err_line, err_frame, frame_cnt}, e_st);
    endtask

    task automatic do_line(input int len, input int rst_at, input int vs_hold);
        for (int i = 0; i < len; i++) begin
            step(1'b1, i < vs_hold, i == rst_at, i, (vs_hold > 0) && (i == 0), -1);
        end
        step(1'b0, 1'b0, 1'b0, 0, 1'b0, len);
        repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
    endtask

    task automatic do_frame(input int nlines, input int bad_line, input int bad_len,
                            input int rst_line, input bit coincident);
        if (!coincident) begin
            step(1'b0, 1'b1, 1'b0, 0, 1'b1, -1);
            step(1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
            step(1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
            step(1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
            step(1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
        end
        for (int l = 0; l < nlines; l++) begin
            do_line((l == bad_line) ? bad_len : H, (l == rst_line) ? 20 : -1,
                    (coincident && l == 0) ? 3 : 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int nl;
        int bl;
        repeat (3) step(1'b0, 1'b0, 1'b1, 0, 1'b0, -1);

        repeat (3) do_frame(V, -1, 0, -1, 1'b0);
        check_eq("fcnt_clean", 64'(frame_cnt), 64'd2);
        check_eq("lock_clean", 64'(locked), 64'd1);

        do_frame(V, 5, H - 1, -1, 1'b0);
        check_eq("lock_short_line", 64'(locked), 64'd0);
        check_eq("fcnt_short_line", 64'(frame_cnt), 64'd3);

        do_frame(V, -1, 0, -1, 1'b0);
        check_eq("fcnt_after_bad", 64'(frame_cnt), 64'd3);

        do_frame(V - 1, -1, 0, -1, 1'b0);
        do_frame(V, -1, 0, -1, 1'b1);
        check_eq("lock_short_frame", 64'(locked), 64'd0);
        do_frame(V, -1, 0, -1, 1'b0);

        for (int f = 0; f < 2; f++) begin
            nl = int'($urandom_range(V - 1, V + 1));
            bl = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, V - 2)) : -1;
            do_frame(nl, bl, int'($urandom_range(H - 4, H + 4)), -1, 1'b0);
        end

        do_frame(V, -1, 0, 10, 1'b0);
        check_eq("lock_after_rst", 64'(locked), 64'd0);
        check_eq("fcnt_after_rst", 64'(frame_cnt), 64'd0);

        do_frame(V, -1, 0, -1, 1'b0);
        do_frame(V, 2, XMAX + 5, -1, 1'b0);
        do_frame(0, -1, 0, -1, 1'b0);
        check_eq("fcnt_end", 64'(frame_cnt), 64'd1);
        check_eq("lock_end", 64'(locked), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
